note_sequencer: RTL and testbench

//  Parametrised note recorder/player: successor to the fixed control/datapath note store.

---
 rtl/note_sequencer_if.sv | 33 +++
 rtl/note_sequencer.sv | 120 ++++++++++++
 tb/tb_note_sequencer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/note_sequencer_if.sv
// Control/record/playback signal bundle between the keyboard front end and the
// note sequencer. The sequencer takes the slave side.
interface note_sequencer_if #(
    parameter int DEPTH  = 16,
    parameter int NOTE_W = 4,
    parameter int OCT_W  = 2
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              rec_valid;
    logic [NOTE_W-1:0] note_in;
    logic [OCT_W-1:0]  octave_in;
    logic              play;
    logic              stop;
    logic              clear;
    logic              loop_en;
    logic [NOTE_W-1:0] note_out;
    logic [OCT_W-1:0]  octave_out;
    logic              note_active;
    logic              step_pulse;
    logic [CNT_W-1:0]  count;
    logic              full;

    modport master (
        output rec_valid, note_in, octave_in, play, stop, clear, loop_en,
        input  note_out, octave_out, note_active, step_pulse, count, full
    );

    modport slave (
        input  rec_valid, note_in, octave_in, play, stop, clear, loop_en,
        output note_out, octave_out, note_active, step_pulse, count, full
    );
endinterface

// File: rtl/note_sequencer.sv
// Records (note, octave) pairs into a DEPTH-entry buffer and plays them back,
// holding each entry for TICKS_PER_STEP cycles, one-shot or looped.
module note_sequencer #(
    parameter int DEPTH          = 16,
    parameter int NOTE_W         = 4,
    parameter int OCT_W          = 2,
    parameter int TICKS_PER_STEP = 12_500_000
) (
    input  logic                clk,
    input  logic                reset,
    note_sequencer_if.slave     bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int ENT_W  = OCT_W + NOTE_W;
    localparam int TICK_W = $clog2(TICKS_PER_STEP);

    typedef enum logic {IDLE, PLAY} state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  count, count_n;
    logic [PTR_W-1:0]  rd_ptr, rd_ptr_n;
    logic [TICK_W-1:0] tick, tick_n;
    logic [ENT_W-1:0]  ent_q, ent_n;
    logic              active_q, active_n;
    logic              step_q, step_n;
    logic              full_q;
    logic              wr_en;
    logic              last_ent;
    logic              tick_end;

    logic [ENT_W-1:0]  mem [DEPTH];

    assign last_ent = ({1'b0, rd_ptr} + CNT_W'(1)) >= count;
    assign tick_end = (tick == TICK_W'(TICKS_PER_STEP - 1));

    // Priority chain: clear > stop > play > record/step.
    always_comb begin
        state_n  = state;
        count_n  = count;
        rd_ptr_n = rd_ptr;
        tick_n   = tick;
        ent_n    = '0;
        active_n = 1'b0;
        step_n   = 1'b0;
        wr_en    = 1'b0;
        if (bus.clear) begin
            state_n = IDLE;
            count_n = '0;
        end else if (bus.stop) begin
            state_n = IDLE;
        end else if (bus.play) begin
            if (count != '0) begin
                state_n  = PLAY;
                rd_ptr_n = '0;
                tick_n   = '0;
                ent_n    = mem[0];
                active_n = 1'b1;
            end
        end else if (state == IDLE) begin
            if (bus.rec_valid && !full_q) begin
                wr_en   = 1'b1;
                count_n = count + CNT_W'(1);
            end
        end else begin
            active_n = 1'b1;
            ent_n    = ent_q;
            tick_n   = tick + TICK_W'(1);
            if (tick_end) begin
                tick_n = '0;
                step_n = 1'b1;
                if (!last_ent) begin
                    rd_ptr_n = rd_ptr + PTR_W'(1);
                    ent_n    = mem[rd_ptr + PTR_W'(1)];
                end else if (bus.loop_en) begin
                    rd_ptr_n = '0;
                    ent_n    = mem[0];
                end else begin
                    state_n  = IDLE;
                    ent_n    = '0;
                    active_n = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= '0;
            rd_ptr   <= '0;
            tick     <= '0;
            ent_q    <= '0;
            active_q <= 1'b0;
            step_q   <= 1'b0;
            full_q   <= 1'b0;
        end else begin
            state    <= state_n;
            count    <= count_n;
            rd_ptr   <= rd_ptr_n;
            tick     <= tick_n;
            ent_q    <= ent_n;
            active_q <= active_n;
            step_q   <= step_n;
            full_q   <= (count_n == CNT_W'(DEPTH));
        end
    end

    // Buffer storage is not reset; only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (wr_en) mem[count[PTR_W-1:0]] <= {bus.octave_in, bus.note_in};
    end

    assign bus.note_out    = ent_q[NOTE_W-1:0];
    assign bus.octave_out  = ent_q[ENT_W-1:NOTE_W];
    assign bus.note_active = active_q;
    assign bus.step_pulse  = step_q;
    assign bus.count       = count;
    assign bus.full        = full_q;
endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: a queue-based reference model predicts
// every cycle's outputs; a negedge monitor pops and compares.
module tb_note_sequencer;
    localparam int DEPTH  = 4;
    localparam int NOTE_W = 4;
    localparam int OCT_W  = 2;
    localparam int TPS    = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    note_sequencer_if #(.DEPTH(DEPTH), .NOTE_W(NOTE_W), .OCT_W(OCT_W)) bus ();

    note_sequencer #(.DEPTH(DEPTH), .NOTE_W(NOTE_W), .OCT_W(OCT_W), .TICKS_PER_STEP(TPS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] note;
        logic [1:0] oct;
        logic       active;
        logic       step;
        logic [2:0] count;
        logic       full;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    // Reference model: buffer as a queue, playback as index + cycles remaining.
    logic [5:0] mbuf[$];
    bit         playing = 0;
    int         idx     = 0;
    int         remain  = 0;
    bit         loop_lv = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    endtask

    always @(negedge clk) begin
        exp_t e, g;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = '{note: bus.note_out, oct: bus.octave_out, active: bus.note_active,
                  step: bus.step_pulse, count: bus.count, full: bus.full};
            checks++;
            if (g == e) passed++;
            else $display("FAIL outputs @%0t: got note=%0d oct=%0d act=%0b step=%0b cnt=%0d full=%0b expected note=%0d oct=%0d act=%0b step=%0b cnt=%0d full=%0b",
                          $time, g.note, g.oct, g.active, g.step, g.count, g.full,
                          e.note, e.oct, e.active, e.step, e.count, e.full);
        end
    end

    // One clock of stimulus; called at negedge+1, returns at next negedge+1.
    task automatic cyc(input bit rec, input logic [3:0] n, input logic [1:0] o,
                       input bit pl, input bit st, input bit cl);
        exp_t       e;
        bit         step;
        logic [5:0] ent;
        bus.rec_valid = rec; bus.note_in = n; bus.octave_in = o;
        bus.play = pl; bus.stop = st; bus.clear = cl; bus.loop_en = loop_lv;
        step = 0;
        if (cl) begin
            mbuf.delete();
            playing = 0;
        end else if (st) begin
            playing = 0;
        end else if (pl) begin
            if (mbuf.size() > 0) begin playing = 1; idx = 0; remain = TPS; end
        end else if (!playing) begin
            if (rec && mbuf.size() < DEPTH) mbuf.push_back({o, n});
        end else begin
            remain--;
            if (remain == 0) begin
                step = 1; remain = TPS; idx++;
                if (idx == mbuf.size()) begin
                    if (loop_lv) idx = 0;
                    else playing = 0;
                end
            end
        end
        ent = playing ? mbuf[idx] : 6'd0;
        e.note = ent[3:0]; e.oct = ent[5:4]; e.active = playing; e.step = step;
        e.count = 3'(mbuf.size()); e.full = (mbuf.size() == DEPTH);
        exp_q.push_back(e);
        @(negedge clk); #1;
    endtask

    task automatic idle(input int k);
        repeat (k) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic rec(input logic [3:0] n, input logic [1:0] o);
        cyc(1, n, o, 0, 0, 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".note_out"}, int'(bus.note_out), 0);
        chk({tag, ".octave_out"}, int'(bus.octave_out), 0);
        chk({tag, ".note_active"}, int'(bus.note_active), 0);
        chk({tag, ".step_pulse"}, int'(bus.step_pulse), 0);
        chk({tag, ".count"}, int'(bus.count), 0);
        chk({tag, ".full"}, int'(bus.full), 0);
    endtask

    initial begin
        bus.rec_valid = 0; bus.note_in = 0; bus.octave_in = 0;
        bus.play = 0; bus.stop = 0; bus.clear = 0; bus.loop_en = 0;
        @(negedge clk); #1;
        check_zero("reset");
        @(negedge clk); #1;
        reset = 1'b1;

        // Record 5,3,9 and sit idle
        rec(5, 1); rec(3, 2); rec(9, 0); idle(3);
        // One-shot playback
        loop_lv = 0; cyc(0, 0, 0, 1, 0, 0); idle(14);
        // Looped playback then stop
        loop_lv = 1; cyc(0, 0, 0, 1, 0, 0); idle(17); cyc(0, 0, 0, 0, 1, 0); idle(2);
        // Restart mid second note
        cyc(0, 0, 0, 1, 0, 0); idle(5); cyc(0, 0, 0, 1, 0, 0); idle(6);
        cyc(0, 0, 0, 0, 1, 0); loop_lv = 0;
        // Empty buffer ignores play; record beyond full
        cyc(0, 0, 0, 0, 0, 1); cyc(0, 0, 0, 1, 0, 0); idle(3);
        rec(1, 0); rec(2, 1); rec(3, 2); rec(4, 3); rec(7, 1); rec(8, 2); idle(1);
        cyc(0, 0, 0, 1, 0, 0); idle(18);
        // rec_valid ignored during play, clear wins over rec
        cyc(0, 0, 0, 1, 0, 0); rec(11, 1); idle(2); cyc(1, 6, 1, 0, 0, 1); idle(2);
        // Single entry loops on itself
        loop_lv = 1; rec(12, 3); cyc(0, 0, 0, 1, 0, 0); idle(10);
        loop_lv = 0; idle(6);

        // Async reset while playing
        rec(13, 2); rec(14, 1); cyc(0, 0, 0, 1, 0, 0); idle(5);
        chk("pre_reset.note_active", int'(bus.note_active), 1);
        reset = 1'b0; #1;
        check_zero("mid_reset");
        mbuf.delete(); playing = 0;
        @(negedge clk); #1;
        reset = 1'b1;

        // Randomized phase
        for (int i = 0; i < 2000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 19) == 0) loop_lv = ~loop_lv;
            cyc(r >= 55, 4'($urandom), 2'($urandom), (r >= 5 && r < 10),
                (r >= 2 && r < 5), (r < 2));
        end
        idle(2);
        @(negedge clk); #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
